// File: rtl/div_pkg.sv
// Shared definitions for the sequential 32-bit divider: operand width,
// controller state encoding and the divide-by-zero quotient value.
package div_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  localparam logic [WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference when
// it does not borrow.
module div_step
  import div_pkg::*;
(
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Shifted remainder is 33 bits wide; its top bit alone guarantees the
  // subtraction succeeds, so only the low 32 bits go through the subtractor.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = {1'b0, shifted[WIDTH-1:0]} - {1'b0, divisor_i};
    q_bit_o = shifted[WIDTH] | ~diff[WIDTH];
    rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider_32_bit.sv
// Sequential 32-bit restoring divider, one quotient bit per clock.
// Optional macro DIV_SIGNED_EN adds input signed_op for two's-complement
// division (magnitude divide plus sign fix-up when results are written).
module seq_divider_32_bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
`ifdef DIV_SIGNED_EN
  ,
  input  logic             signed_op
`endif
);

  import div_pkg::*;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [WIDTH-1:0]       dvd_q;
  logic [WIDTH-1:0]       dvs_q;
  logic [WIDTH-1:0]       rem_q;
  logic [WIDTH-1:0]       quotient_q;
  logic [WIDTH-1:0]       remainder_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   dbz_q;
  logic                   qneg_q;
  logic                   rneg_q;

  logic [WIDTH-1:0]       dvd_mag_d;
  logic [WIDTH-1:0]       dvs_mag_d;
  logic                   qneg_d;
  logic                   rneg_d;
  logic [WIDTH-1:0]       step_rem;
  logic                   step_q;
  logic [WIDTH-1:0]       q_final;
  logic [WIDTH-1:0]       quotient_d;
  logic [WIDTH-1:0]       remainder_d;

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

  // Operand magnitudes and result signs captured on an accepted start.
  always_comb begin
    dvd_mag_d = dividend;
    dvs_mag_d = divisor;
    qneg_d    = 1'b0;
    rneg_d    = 1'b0;
`ifdef DIV_SIGNED_EN
    if (signed_op) begin
      dvd_mag_d = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
      dvs_mag_d = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
      qneg_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      rneg_d    = dividend[WIDTH-1];
    end
`endif
  end

  // The dividend register doubles as the quotient shift register: each
  // iteration consumes its MSB and shifts the new quotient bit into the LSB.
  div_step u_div_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  // Final-iteration results with sign restored (no-op for unsigned).
  always_comb begin
    q_final     = {dvd_q[WIDTH-2:0], step_q};
    quotient_d  = qneg_q ? (~q_final + 1'b1) : q_final;
    remainder_d = rneg_q ? (~step_rem + 1'b1) : step_rem;
  end

  // Controller: operand capture, 32 iterations, one-cycle done in FINISH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RUN: begin
          rem_q <= step_rem;
          dvd_q <= q_final;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q     <= FINISH;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
          end
        end
        default: begin
          if (start) begin
            dvd_q  <= dvd_mag_d;
            dvs_q  <= dvs_mag_d;
            rem_q  <= '0;
            cnt_q  <= '0;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            if (divisor == '0) begin
              state_q     <= FINISH;
              done_q      <= 1'b1;
              dbz_q       <= 1'b1;
              quotient_q  <= DIV_ZERO_QUOT;
              remainder_q <= dividend;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              dbz_q   <= 1'b0;
            end
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_32_bit.sv
// Directed bench for seq_divider_32_bit. Edge numbering: the edge that
// samples start is edge 0; a value first seen just after edge k is the
// value sampled at edge k+1.
module tb_seq_divider_32_bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic        signed_op;

  int checks = 0;
  int errors = 0;

  seq_divider_32_bit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
`ifdef DIV_SIGNED_EN
    ,
    .signed_op   (signed_op)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present operands at the falling edge; returns #1 after the capture edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    signed_op = sgn;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done; k0 is the number of edges already elapsed.
  task automatic wait_done(input int k0, output int edge_idx);
    int k;
    k = k0;
    edge_idx = -1;
    while (k <= 40) begin
      if (done) begin
        edge_idx = k + 1;
        break;
      end
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [31:0] eq, input logic [31:0] er,
                         input logic edbz, input int eedge);
    int e;
    start_op(a, b, sgn);
    wait_done(0, e);
    $display("txn %s: %08h / %08h -> q=%08h r=%08h dbz=%0b done_edge=%0d",
             tag, a, b, quotient, remainder, div_by_zero, e);
    check({tag, "_edge"}, 32'(e), 32'(eedge));
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int e;
    int done_seen;
    rst_n     = 1'b0;
    start     = 1'b0;
    dividend  = '0;
    divisor   = '0;
    signed_op = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic division and latency
    start_op(32'd100, 32'd7, 1'b0);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    wait_done(0, e);
    $display("txn 100/7: q=%08h r=%08h done_edge=%0d", quotient, remainder, e);
    check("d100_edge", 32'(e), 32'd33);
    check("d100_q", quotient, 32'd14);
    check("d100_r", remainder, 32'd2);
    check("d100_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("d100_hold_q", quotient, 32'd14);
    check("d100_idle_busy", {31'd0, busy}, 32'd0);

    run_div("max_by_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    run_div("5_by_msb", 32'd5, 32'h8000_0000, 1'b0, 32'd0, 32'd5, 1'b0, 33);
    run_div("big_by_big", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32'd1, 32'h7FFF_FFFE, 1'b0, 33);
    run_div("by_zero", 32'd1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1);

    // Start during RUN is ignored; also clears div_by_zero on acceptance
    start_op(32'd100, 32'd7, 1'b0);
    check("dbz_cleared", {31'd0, div_by_zero}, 32'd0);
    repeat (9) @(posedge clk);
    start_op(32'd50, 32'd5, 1'b0);
    wait_done(10, e);
    $display("txn ignore: q=%08h r=%08h done_edge=%0d", quotient, remainder, e);
    check("ign_edge", 32'(e), 32'd33);
    check("ign_q", quotient, 32'd14);
    check("ign_r", remainder, 32'd2);
    @(posedge clk);
    #1;

    // Reset mid-operation
    start_op(32'd100, 32'd7, 1'b0);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_q", quotient, 32'd0);
    check("abort_r", remainder, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) done_seen = 1;
    end
    $display("txn abort: done_seen=%0d", done_seen);
    check("abort_no_done", 32'(done_seen), 32'd0);
    run_div("9_by_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 33);

`ifdef DIV_SIGNED_EN
    run_div("s_m7_by_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    run_div("s_min_by_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33);
    run_div("s_7_by_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider_32_bit.md
SEQ_DIVIDER_32_BIT -- requirements
Module: seq_divider_32_bit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand and result width in bits; only 32 is supported.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: start  input  1  request a division; sampled only when not busy.
REQ-005 SHALL have port: dividend  input  32  numerator; captured on an accepted start.
REQ-006 SHALL have port: divisor  input  32  denominator; captured on an accepted start.
REQ-007 SHALL have port: quotient  output  32  registered result.
REQ-008 SHALL have port: remainder  output  32  registered result.
REQ-009 SHALL have port: busy  output  1  high while a division is in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse when results become valid.
REQ-011 SHALL have port: div_by_zero  output  1  high with done when the captured divisor is 0; held until the next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and FINISH.
REQ-013 SHALL accept start in IDLE or FINISH: capture operands, clear div_by_zero, and enter RUN (divisor nonzero) or FINISH (divisor zero).
REQ-014 SHALL ignore start while in RUN; captured operands and the iteration count are unaffected.
REQ-015 SHALL perform unsigned restoring division in RUN, resolving one quotient bit per cycle MSB-first with a 6-bit iteration counter, for exactly 32 cycles.
REQ-016 SHALL use a 33-bit partial-remainder subtractor so that no borrow is lost when the divisor has bit 31 set.
REQ-017 SHALL enter FINISH after the 32nd RUN cycle; done is high for exactly the one cycle spent in FINISH.
REQ-018 SHALL, for start sampled at edge N with a nonzero divisor, assert busy from edge N+1 through edge N+32 and assert done at edge N+33.
REQ-019 SHALL, on divisor zero, set quotient = 0xFFFFFFFF, remainder = dividend, and div_by_zero = 1, with done at edge N+1.
REQ-020 SHALL return from FINISH to IDLE when start is low, or back to RUN when start is high (back-to-back operations).
REQ-021 SHALL hold quotient and remainder stable from done until the next accepted start, and SHALL update them only at done.

Reset
REQ-022 SHALL, while rst_n is low, force state IDLE, counter 0, and quotient, remainder, busy, done, and div_by_zero all 0.
REQ-023 SHALL abort any operation in progress when rst_n asserts, discarding it with no done pulse.

Configuration
REQ-024 SHALL support macro DIV_SIGNED_EN: when defined, input port signed_op (1 bit, captured with the operands) is added.
REQ-025 SHALL, with DIV_SIGNED_EN defined and signed_op = 1, divide two's-complement operands via magnitude division plus sign fix-up: quotient truncated toward zero, remainder sign equal to the dividend sign, and 0x80000000 / 0xFFFFFFFF giving quotient 0x80000000 and remainder 0.
REQ-026 SHALL keep signed-mode latency identical to REQ-018, with sign fix-up applied when entering FINISH.
REQ-027 SHALL, with DIV_SIGNED_EN undefined, omit port signed_op and support unsigned division only.

Structure
REQ-028 SHALL place the following in shared package div_pkg: the WIDTH constant, the FSM state typedef (IDLE/RUN/FINISH), and the divide-by-zero quotient constant 0xFFFFFFFF.
REQ-029 SHALL instantiate one combinational sub-module, div_step, that performs one shift-compare-subtract iteration and returns the next partial remainder and the quotient bit.

Verification
REQ-030 SHALL verify: 100 / 7, start at edge 0 -> done at edge 33, quotient 14, remainder 2, div_by_zero 0.
REQ-031 SHALL verify: 0xFFFFFFFF / 1 and 5 / 0x80000000 -> quotient 0xFFFFFFFF, remainder 0; then quotient 0, remainder 5.
REQ-032 SHALL verify: 1234 / 0 -> done at edge 1, quotient 0xFFFFFFFF, remainder 1234, div_by_zero 1.
REQ-033 SHALL verify: a second start at RUN cycle 10 with new operands -> ignored; the first result is still correct at edge 33.
REQ-034 SHALL verify: rst_n low at RUN cycle 15 -> all outputs 0 and no done pulse; a fresh 9 / 3 after release -> quotient 3, remainder 0.
REQ-035 SHALL verify, with DIV_SIGNED_EN defined: -7 / 2 signed -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; and 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
